// File: rtl/switch_press_counter_pkg.sv
// Shared constants for the Go Board button projects.
// The count width matches the dual 7-segment driver's input.
package switch_press_counter_pkg;

    localparam int unsigned c_DEBOUNCE_25MHZ_10MS = 250000;
    localparam int unsigned c_COUNT_WIDTH         = 8;

    typedef logic [c_COUNT_WIDTH-1:0] count_t;

endpackage

// File: rtl/switch_press_counter_if.sv
// Switch/clear inputs and count/strobe/level outputs of the press counter.
interface switch_press_counter_if;
    import switch_press_counter_pkg::*;

    logic   i_Switch;
    logic   i_Clear;
    count_t o_Count;
    logic   o_Press_Pulse;
    logic   o_Switch_Debounced;

    modport master (
        output i_Switch,
        output i_Clear,
        input  o_Count,
        input  o_Press_Pulse,
        input  o_Switch_Debounced
    );

    modport slave (
        input  i_Switch,
        input  i_Clear,
        output o_Count,
        output o_Press_Pulse,
        output o_Switch_Debounced
    );

endinterface

// File: rtl/switch_press_counter_debounce_filter.sv
// Two-flop pin synchronizer followed by a hold-time debounce filter.
// A new level is accepted only after DEBOUNCE_LIMIT consecutive differing cycles.
module switch_press_counter_debounce_filter
    import switch_press_counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT = c_DEBOUNCE_25MHZ_10MS
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Bouncy,
    output logic o_Debounced
);

    localparam int unsigned      CntW   = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_LIMIT - 1);

    logic [1:0]      sync_q;
    logic            s_sync;
    logic            stable_q, stable_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    assign s_sync = sync_q[1];

    // Any cycle matching the stable level restarts the hold count.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (s_sync != stable_q) begin
            if (cnt_q == CntMax) begin
                stable_d = s_sync;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[0], i_Bouncy};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_Debounced = stable_q;

endmodule

// File: rtl/switch_press_counter.sv
// Counts debounced button presses (or releases) into a wrapping 8-bit total
// with a one-cycle strobe on each increment; clear wins over a coincident press.
module switch_press_counter
    import switch_press_counter_pkg::*;
#(
    parameter int unsigned DEBOUNCE_LIMIT   = c_DEBOUNCE_25MHZ_10MS,
    parameter bit          COUNT_ON_RELEASE = 1'b0
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    switch_press_counter_if.slave  bus_io
);

    logic   stable;
    logic   prev_q;
    logic   evt;
    count_t count_q, count_d;
    logic   pulse_q, pulse_d;

    switch_press_counter_debounce_filter #(
        .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT)
    ) u_debounce (
        .i_Clk       (i_Clk),
        .i_Rst_L     (i_Rst_L),
        .i_Bouncy    (bus_io.i_Switch),
        .o_Debounced (stable)
    );

    assign evt = COUNT_ON_RELEASE ? (~stable & prev_q) : (stable & ~prev_q);

    always_comb begin
        count_d = count_q;
        pulse_d = 1'b0;
        if (bus_io.i_Clear) begin
            count_d = '0;
        end else if (evt) begin
            count_d = count_q + 1'b1;
            pulse_d = 1'b1;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            prev_q  <= 1'b0;
            count_q <= '0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= stable;
            count_q <= count_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus_io.o_Count            = count_q;
    assign bus_io.o_Press_Pulse      = pulse_q;
    assign bus_io.o_Switch_Debounced = stable;

endmodule

// File: tb/tb_switch_press_counter.sv
// Bench for switch_press_counter: one press-mode and one release-mode instance
// share the switch stimulus; a per-instance queue holds the expected count per strobe.
module tb_switch_press_counter;

    localparam int unsigned LIM = 4;

    logic clk;
    logic rst_n;

    switch_press_counter_if bus_p ();
    switch_press_counter_if bus_r ();

    switch_press_counter #(
        .DEBOUNCE_LIMIT   (LIM),
        .COUNT_ON_RELEASE (1'b0)
    ) u_dut_press (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus_io  (bus_p)
    );

    switch_press_counter #(
        .DEBOUNCE_LIMIT   (LIM),
        .COUNT_ON_RELEASE (1'b1)
    ) u_dut_rel (
        .i_Clk   (clk),
        .i_Rst_L (rst_n),
        .bus_io  (bus_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_pulse_p = 0;
    int         n_pulse_r = 0;
    logic [7:0] p_exp = 8'h00;
    logic [7:0] r_exp = 8'h00;
    logic [7:0] q_p[$];
    logic [7:0] q_r[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_sw(input logic v);
        bus_p.i_Switch = v;
        bus_r.i_Switch = v;
    endtask

    task automatic do_reset(input int n);
        check_val("sb_press_drained", q_p.size(), 0);
        check_val("sb_rel_drained", q_r.size(), 0);
        q_p.delete();
        q_r.delete();
        rst_n = 1'b0;
        tick(n);
        p_exp = 8'h00;
        r_exp = 8'h00;
        rst_n = 1'b1;
    endtask

    // Press accepted when held >= LIM; low period is always long enough to release.
    task automatic press(input int hold, input int low);
        set_sw(1'b1);
        if (hold >= int'(LIM)) begin
            p_exp++;
            q_p.push_back(p_exp);
        end
        tick(hold);
        set_sw(1'b0);
        if (hold >= int'(LIM)) begin
            r_exp++;
            q_r.push_back(r_exp);
        end
        tick(low);
    endtask

    // Strobe monitors: every strobe must match the oldest expected count.
    always @(negedge clk) begin
        if (bus_p.o_Press_Pulse === 1'b1) begin
            n_pulse_p++;
            if (q_p.size() == 0) check_val("press_spurious_pulse", 1, 0);
            else                 check_val("press_count_at_pulse", bus_p.o_Count, q_p.pop_front());
        end
        if (bus_r.o_Press_Pulse === 1'b1) begin
            n_pulse_r++;
            if (q_r.size() == 0) check_val("rel_spurious_pulse", 1, 0);
            else                 check_val("rel_count_at_pulse", bus_r.o_Count, q_r.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        int base_p;
        rst_n         = 1'b0;
        bus_p.i_Clear = 1'b0;
        bus_r.i_Clear = 1'b0;
        set_sw(1'b0);
        tick(1);

        // 1. reset then idle
        do_reset(3);
        tick(20);
        check_val("idle_count", bus_p.o_Count, 8'h00);
        check_val("idle_pulse", bus_p.o_Press_Pulse, 1'b0);
        check_val("idle_deb", bus_p.o_Switch_Debounced, 1'b0);
        check_val("idle_count_rel", bus_r.o_Count, 8'h00);

        // 2. clean press: debounced level 6 cycles after pin, strobe the cycle after
        set_sw(1'b1);
        p_exp++;
        q_p.push_back(p_exp);
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            check_val($sformatf("deb_latency_k%0d", k), bus_p.o_Switch_Debounced, (k >= 6));
            check_val($sformatf("pulse_timing_k%0d", k), bus_p.o_Press_Pulse, (k == 7));
        end
        check_val("clean_count", bus_p.o_Count, 8'h01);
        check_val("rel_no_count_on_press", bus_r.o_Count, 8'h00);
        tick(2);
        set_sw(1'b0);
        r_exp++;
        q_r.push_back(r_exp);
        tick(10);
        check_val("rel_count_on_release", bus_r.o_Count, 8'h01);
        check_val("press_hold_after_release", bus_p.o_Count, 8'h01);

        // 3. bounce rejection, short press, and exact-limit boundary
        for (int i = 0; i < 4; i++) begin
            set_sw(i[0] ? 1'b0 : 1'b1);
            tick(2);
        end
        press(10, 10);
        check_val("bounce_one_count", bus_p.o_Count, 8'h02);
        press(3, 10);
        check_val("short_press_ignored", bus_p.o_Count, 8'h02);
        check_val("short_press_ignored_rel", bus_r.o_Count, 8'h02);
        press(4, 10);
        check_val("limit_press_counted", bus_p.o_Count, 8'h03);
        press(8, 10);
        press(8, 10);
        check_val("pre_clear_count", bus_p.o_Count, 8'h05);

        // 5. clear on the exact cycle evt fires on the press instance
        set_sw(1'b1);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus_p.o_Switch_Debounced === 1'b1) seen = 1'b1;
        end
        check_val("clear_wait_deb", seen, 1'b1);
        bus_p.i_Clear = 1'b1;
        @(posedge clk);
        #1;
        bus_p.i_Clear = 1'b0;
        p_exp = 8'h00;
        @(negedge clk);
        check_val("clear_collision_count", bus_p.o_Count, 8'h00);
        check_val("clear_collision_pulse", bus_p.o_Press_Pulse, 1'b0);
        tick(2);
        set_sw(1'b0);
        r_exp++;
        q_r.push_back(r_exp);
        tick(10);
        press(8, 10);
        check_val("post_clear_count", bus_p.o_Count, 8'h01);
        check_val("rel_unaffected_by_clear", bus_r.o_Count, 8'h07);

        // 4. wrap after 256 presses
        do_reset(2);
        base_p = n_pulse_p;
        for (int i = 0; i < 256; i++) press(6, 8);
        check_val("wrap_pulse_total", n_pulse_p - base_p, 256);
        check_val("wrap_count", bus_p.o_Count, 8'h00);
        check_val("wrap_count_rel", bus_r.o_Count, 8'h00);
        press(6, 8);
        check_val("after_wrap_count", bus_p.o_Count, 8'h01);

        // 6. reset mid-debounce (hold count at 2), no pulse after release of reset
        check_val("sb_press_drained_t6", q_p.size(), 0);
        check_val("sb_rel_drained_t6", q_r.size(), 0);
        set_sw(1'b1);
        tick(4);
        rst_n = 1'b0;
        tick(1);
        @(negedge clk);
        check_val("midrst_count", bus_p.o_Count, 8'h00);
        check_val("midrst_pulse", bus_p.o_Press_Pulse, 1'b0);
        check_val("midrst_deb", bus_p.o_Switch_Debounced, 1'b0);
        check_val("midrst_count_rel", bus_r.o_Count, 8'h00);
        set_sw(1'b0);
        tick(2);
        p_exp = 8'h00;
        r_exp = 8'h00;
        rst_n = 1'b1;
        tick(20);
        check_val("post_rst_count", bus_p.o_Count, 8'h00);
        check_val("post_rst_deb", bus_p.o_Switch_Debounced, 1'b0);
        check_val("post_rst_count_rel", bus_r.o_Count, 8'h00);
        press(8, 10);
        check_val("post_rst_press", bus_p.o_Count, 8'h01);
        check_val("post_rst_rel", bus_r.o_Count, 8'h01);

        check_val("sb_press_empty", q_p.size(), 0);
        check_val("sb_rel_empty", q_r.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_press_counter.md
Name: switch_press_counter

Overview:
Counts debounced presses of a Go Board push-button and presents the running total as an 8-bit value. It feeds the dual 7-segment display driver directly: o_Count wires straight to that driver's i_Count, and the display shows the upper and lower hex nibbles. The block contains a pin synchronizer, a debounce filter, an edge detector and a wrapping press counter.

Parameters:
DEBOUNCE_LIMIT, 250000, consecutive cycles a new input level must hold before it is accepted (10 ms at 25 MHz); legal range 2..2^20.
COUNT_ON_RELEASE, 0, 0 = count on the press edge (debounced 0->1); 1 = count on the release edge (1->0).

Ports:
i_Clk  input  1  system clock (25 MHz); the only clock.
i_Rst_L  input  1  reset; synchronous, active-low.
i_Switch  input  1  raw switch pin, asynchronous and bouncy; 1 = pressed.
i_Clear  input  1  synchronous clear of the count; level-sensitive, active-high.
o_Count  output  8  running press count; feeds the display driver's i_Count.
o_Press_Pulse  output  1  single-cycle strobe, high on each cycle o_Count advances due to a press.
o_Switch_Debounced  output  1  filtered switch level.

Behaviour:
- Reset (i_Rst_L=0 at a rising edge): synchronizer flops, debounce counter, stable level, edge-history flop, o_Count, o_Press_Pulse and o_Switch_Debounced all go to 0. Reset has priority over every other input. Reset asserted mid-debounce discards the partial count.
- Synchronizer: two flops on i_Switch give s_sync. There is a fixed 2-cycle delay from pin to s_sync.
- Debounce filter (state: r_stable, r_cnt of ceil(log2(DEBOUNCE_LIMIT)) bits):
  - If s_sync == r_stable, then r_cnt <= 0.
  - If s_sync != r_stable and r_cnt < DEBOUNCE_LIMIT-1, then r_cnt <= r_cnt+1.
  - If s_sync != r_stable and r_cnt == DEBOUNCE_LIMIT-1, then r_stable <= s_sync and r_cnt <= 0.
  - Net effect: the level must differ for DEBOUNCE_LIMIT consecutive cycles. Any glitch back to r_stable restarts the count from 0.
  - o_Switch_Debounced = r_stable. Total pin-to-output latency is 2 + DEBOUNCE_LIMIT cycles.
- Edge detect: r_prev <= r_stable each cycle. The edge condition is evt = r_stable & ~r_prev (COUNT_ON_RELEASE=0) or ~r_stable & r_prev (COUNT_ON_RELEASE=1).
- Counter and pulse, registered, with this priority:
  1. Reset.
  2. i_Clear: o_Count <= 0 and o_Press_Pulse <= 0. Clear wins over a simultaneous evt; that press is lost.
  3. evt: o_Count <= o_Count + 1, modulo 256, so 0xFF wraps to 0x00. o_Press_Pulse <= 1.
  4. Otherwise hold the count and set o_Press_Pulse <= 0.
- The count update and o_Press_Pulse assert on the same edge, one cycle after o_Switch_Debounced changes.
- i_Clear held high keeps o_Count at 0 throughout. The debounce path keeps running during clear.
- Each accepted press produces exactly one increment, independent of press duration. A press shorter than DEBOUNCE_LIMIT cycles produces no increment.
- All outputs are registered; there are no combinational input-to-output paths.

Decomposition:
- Shared package (GoBoard_Pkg):
  - c_DEBOUNCE_25MHZ_10MS = 250000
  - c_COUNT_WIDTH = 8, shared with the display driver's input width
- Natural sub-module: debounce_filter (synchronizer plus filter). Ports are i_Clk, i_Rst_L, i_Bouncy, o_Debounced; parameter DEBOUNCE_LIMIT. It is reused by the other button projects.
- Edge detect and counter stay in the top of this block.

Test Plan (simulate with DEBOUNCE_LIMIT=4):
1. Reset then idle: hold i_Rst_L=0 for 3 cycles, release, i_Switch=0 for 20 cycles -> o_Count=0x00, o_Press_Pulse never high, o_Switch_Debounced=0.
2. Clean press: i_Switch 0->1 held 10 cycles -> o_Switch_Debounced rises exactly 6 cycles after the pin change; o_Press_Pulse is high for 1 cycle the next cycle; o_Count=0x01.
3. Bounce rejection: i_Switch toggles 1,0,1,0 each for 2 cycles, then 1 held 10 cycles -> exactly one pulse; o_Count 0x00->0x01. A 3-cycle-wide pulse alone -> no change.
4. Wrap: 256 clean presses from reset -> o_Count goes 0xFE, 0xFF, 0x00; a pulse fires on each press, including the wrap.
5. Clear collision: o_Count=0x05; assert i_Clear in the same cycle evt fires -> o_Count=0x00, o_Press_Pulse=0. The next press gives 0x01.
6. Reset mid-debounce and release mode: with COUNT_ON_RELEASE=1, a press gives no increment and its release gives +1. Assert i_Rst_L=0 with r_cnt=2 -> all outputs are 0 next cycle, and no spurious pulse after reset is released.
